// File: rtl/rs232_pkg.sv
// Shared types for the RS232 transmit path: arbiter FSM states, byte width
// and a one-hot to index encoder for up to eight requesters.
package rs232_pkg;

  localparam int RS232_BYTE_W = 8;
  localparam int RS232_IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } tx_arb_state_t;

  function automatic logic [RS232_IDX_W-1:0] onehot_to_idx(input logic [7:0] oh);
    onehot_to_idx = {|(oh & 8'hF0), |(oh & 8'hCC), |(oh & 8'hAA)};
  endfunction

endpackage

// File: rtl/rs232_rr_pick.sv
// Combinational round-robin pick: lowest active request searching upward from ptr+1,
// wrapping modulo NUM_REQ; returns the one-hot winner and an any-request flag.
module rs232_rr_pick
  import rs232_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]     req_vld,
  input  logic [RS232_IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0]     win,
  output logic                   any
);

  logic [RS232_IDX_W:0] shift;
  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   rot_win;

  // Rotate so bit 0 is requester ptr+1, isolate the lowest set bit, rotate back.
  always_comb begin
    shift   = {1'b0, ptr} + {{RS232_IDX_W{1'b0}}, 1'b1};
    rot_req = NUM_REQ'({req_vld, req_vld} >> shift);
    rot_win = rot_req & (-rot_req);
    win     = NUM_REQ'(({rot_win, rot_win} << shift) >> NUM_REQ);
    any     = |req_vld;
  end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Frame-level round-robin arbiter for one RS232 byte transmitter; first byte on tx_vld two cycles
// after req_vld in IDLE, grant held until the owner's last byte drains (RS232_TX_ARB_TIMEOUT_EN adds stall abort).
module rs232_tx_arbiter
  import rs232_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_vld,
  input  logic [RS232_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_rdy,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            busy,
  output logic [RS232_BYTE_W-1:0]         tx_data,
  output logic                            tx_vld,
  input  logic                            tx_rdy,
  output logic                            frame_abort
);

  tx_arb_state_t           state_q, state_d;
  logic [RS232_IDX_W-1:0]  ptr_q, ptr_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [RS232_BYTE_W-1:0] byte_q, byte_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    tx_vld_q, tx_vld_d;

  logic [NUM_REQ-1:0]      pick_win;
  logic                    pick_any;
  logic [RS232_IDX_W-1:0]  owner_idx;
  logic                    own_vld;
  logic                    own_last;
  logic [RS232_BYTE_W-1:0] own_byte;

`ifdef RS232_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             cnt_hit;
`endif

  rs232_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_vld (req_vld),
    .ptr     (ptr_q),
    .win     (pick_win),
    .any     (pick_any)
  );

  always_comb begin
    owner_idx = onehot_to_idx(8'(grant_q));
    own_vld   = |(req_vld & grant_q);
    own_last  = |(req_last & grant_q);
    own_byte  = RS232_BYTE_W'(req_data >> {owner_idx, 3'b000});
  end

`ifdef RS232_TX_ARB_TIMEOUT_EN
  assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    byte_d  = byte_q;
    last_d  = last_q;
`ifdef RS232_TX_ARB_TIMEOUT_EN
    abort_d = 1'b0;
    cnt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_win;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (own_vld) begin
          byte_d  = own_byte;
          last_d  = own_last;
          state_d = SEND;
        end
`ifdef RS232_TX_ARB_TIMEOUT_EN
        else if (cnt_hit) begin
          abort_d = 1'b1;
          ptr_d   = owner_idx;
          grant_d = '0;
          state_d = IDLE;
        end
`endif
      end
      SEND: begin
        if (!tx_rdy) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // tx_rdy rising again marks the end of the stop bit.
        if (tx_rdy) begin
          if (last_q) begin
            ptr_d   = owner_idx;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
    endcase
    busy_d   = (state_d != IDLE);
    tx_vld_d = (state_d == SEND);
`ifdef RS232_TX_ARB_TIMEOUT_EN
    // Counts only stalled cycles spent continuously in LOAD.
    if (state_q == LOAD && state_d == LOAD) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= RS232_IDX_W'(NUM_REQ - 1);
      grant_q  <= '0;
      byte_q   <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      tx_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      tx_vld_q <= tx_vld_d;
    end
  end

`ifdef RS232_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign frame_abort = abort_q;
`else
  assign frame_abort = 1'b0;
`endif

  assign req_rdy = (state_q == LOAD) ? grant_q : '0;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign tx_data = byte_q;
  assign tx_vld  = tx_vld_q;

endmodule
